regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (write enable, 5-bit address, 32-bit data) between NREQ writeback requesters, e.g. ALU result and load-unit result.
- Uses per-requester valid/ready handshakes and round-robin arbitration.
- Registers the winning write for one cycle before it reaches the register file.
- Sits between the execute/memory stages and Register_File.

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - register-file write port types and constants
// Shared by the writeback arbiter, its round-robin core and the requester interface.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    // x0 is hardwired to zero, so writes aimed at it are swallowed.
    function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] addr);
        return addr == RF_ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester bundle and register-file write port
// master = requester/register-file side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wb_hold;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   busy;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output wb_hold,
        input  req_ready,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  wb_hold,
        output req_ready,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin grant with rotating priority pointer
// Grant is combinational; the pointer moves past the winner only when adv is high.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             found;

    // Two passes: requesters at or above ptr first, then the wrapped-around ones.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PTR_W'(i) >= ptr_q)) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter feeding the register-file write port
// Optional RFWB_FWD_EN adds a bypass of the write landing this cycle to two read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave wb
`ifdef RFWB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]   rd_a1,
    input  logic [ADDR_W-1:0]   rd_a2,
    output logic                fwd1_hit,
    output logic                fwd2_hit,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ready;
    rf_wr_t          rf_q;
    rf_wr_t          rf_d;

    assign arb_req = wb.req_valid & ~{NREQ{wb.wb_hold}};

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .adv   (~wb.wb_hold),
        .grant (grant)
    );

    assign ready        = rst ? '0 : grant;
    assign wb.req_ready = ready;
    assign wb.busy      = rst ? 1'b0 : |(wb.req_valid & ~ready);

    // Address/data follow the winner even for x0; with no winner they are kept.
    always_comb begin
        rf_d.we   = 1'b0;
        rf_d.addr = rf_q.addr;
        rf_d.data = rf_q.data;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                rf_d.we   = ~is_zero_reg(wb.req_addr[i*ADDR_W +: ADDR_W]);
                rf_d.addr = wb.req_addr[i*ADDR_W +: ADDR_W];
                rf_d.data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    assign wb.rf_we    = rf_q.we;
    assign wb.rf_waddr = rf_q.addr;
    assign wb.rf_wdata = rf_q.data;

`ifdef RFWB_FWD_EN
    assign fwd1_hit = rf_q.we && (rf_q.addr == rd_a1) && !is_zero_reg(rd_a1);
    assign fwd2_hit = rf_q.we && (rf_q.addr == rd_a2) && !is_zero_reg(rd_a2);
    assign fwd_data = rf_q.data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized checks of regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          v[NREQ];
    logic [AW-1:0] a[NREQ];
    logic [DW-1:0] d[NREQ];
    logic          hold;

    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [NREQ-1:0] acc;

    int cont_seq[4] = '{5, 6, 5, 6};

    regfile_wb_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) wb ();

`ifdef RFWB_FWD_EN
    logic [AW-1:0] rd_a1;
    logic [AW-1:0] rd_a2;
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [DW-1:0] fwd_data;
`endif

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb)
`ifdef RFWB_FWD_EN
        ,
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .fwd1_hit (fwd1_hit),
        .fwd2_hit (fwd2_hit),
        .fwd_data (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            wb.req_valid[i]          = v[i];
            wb.req_addr[i*AW +: AW]  = a[i];
            wb.req_data[i*DW +: DW]  = d[i];
        end
        wb.wb_hold = hold;
        if (rst) model_reset();
    endtask

    // First valid requester walking forward from the pointer, modulo NREQ.
    function automatic logic [NREQ-1:0] exp_grant();
        logic [NREQ-1:0] g = '0;
        if (rst || hold) return g;
        for (int k = 0; k < NREQ; k++) begin
            int j = (m_ptr + k) % NREQ;
            if (v[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic check_rf(input string tag);
        check({tag, ".rf_we"},    64'(wb.rf_we),    64'(m_we));
        check({tag, ".rf_waddr"}, 64'(wb.rf_waddr), 64'(m_addr));
        check({tag, ".rf_wdata"}, 64'(wb.rf_wdata), 64'(m_data));
    endtask

    task automatic tick(input string tag);
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] vv;
        int idx;
        apply();
        g  = exp_grant();
        vv = '0;
        for (int i = 0; i < NREQ; i++) vv[i] = v[i];
        @(negedge clk);
        check({tag, ".ready"}, 64'(wb.req_ready), 64'(g));
        check({tag, ".busy"},  64'(wb.busy), rst ? 64'(0) : 64'(|(vv & ~g)));
        @(posedge clk);
        acc = g;
        if (!rst) begin
            if (|g) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
                m_ptr  = (idx + 1) % NREQ;
                m_we   = (a[idx] != 0);
                m_addr = a[idx];
                m_data = d[idx];
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        check_rf(tag);
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            a[i] = '0;
            d[i] = '0;
        end
`ifdef RFWB_FWD_EN
        rd_a1 = '0;
        rd_a2 = '0;
`endif
        apply();
        #1;
        check_rf("reset");
        check("reset.ready", 64'(wb.req_ready), 64'(0));
        check("reset.busy",  64'(wb.busy), 64'(0));

        rst = 1'b0;
        tick("idle");

        // request presented in the same cycle reset is asserted
        v[0] = 1'b1; a[0] = 5'd3; d[0] = 32'hAAAA_0001;
        rst = 1'b1;
        tick("rstmid");
        v[0] = 1'b0;
        rst = 1'b0;
        repeat (3) tick("postrst");

        v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'h11;
        v[1] = 1'b1; a[1] = 5'd6; d[1] = 32'h22;
        for (int k = 0; k < 4; k++) begin
            tick("cont");
            check("cont.seq", 64'(wb.rf_waddr), 64'(cont_seq[k]));
        end

        v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a[1] = AW'(7 + k);
            d[1] = 32'h100 + DW'(k);
            tick("single");
            check("single.we", 64'(wb.rf_we), 64'(1));
        end

        v[1] = 1'b0;
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'hDEAD;
        tick("x0");
        check("x0.we", 64'(wb.rf_we), 64'(0));
        a[0] = 5'd13; d[0] = 32'h1;
        v[1] = 1'b1; a[1] = 5'd14; d[1] = 32'h2;
        tick("x0ptr");
        check("x0ptr.waddr", 64'(wb.rf_waddr), 64'(14));

        v[1] = 1'b0;
        a[0] = 5'd10; d[0] = 32'h55;
        hold = 1'b1;
        repeat (3) tick("hold");
        hold = 1'b0;
        tick("release");
        check("release.we", 64'(wb.rf_we), 64'(1));
        v[0] = 1'b0;
        tick("idle2");

        // asynchronous reset while a write is on the port
        v[0] = 1'b1; a[0] = 5'd12; d[0] = 32'h77;
        tick("pre_arst");
        v[0] = 1'b0;
        rst = 1'b1;
        apply();
        #1;
        check_rf("arst");
        #10;
        rst = 1'b0;
        tick("post_arst");

`ifdef RFWB_FWD_EN
        v[0] = 1'b1; a[0] = 5'd4; d[0] = 32'h1234;
        tick("fwd");
        v[0] = 1'b0;
        rd_a1 = 5'd4; rd_a2 = 5'd0;
        #1;
        check("fwd.hit1", 64'(fwd1_hit), 64'(1));
        check("fwd.hit2", 64'(fwd2_hit), 64'(0));
        check("fwd.data", 64'(fwd_data), 64'h1234);
        rd_a2 = 5'd4;
        #1;
        check("fwd.hit2b", 64'(fwd2_hit), 64'(1));
        tick("fwd_idle");
        check("fwd.hit1_off", 64'(fwd1_hit), 64'(0));
`endif

        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        acc = '0;
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !v[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i] = AW'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            tick("rand");
            check("rand.onehot", 64'($countones(wb.req_ready) <= 1), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
